// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: integer register file, 2 combinational reads, 1 clocked write.
// x0 reads as zero; a write in flight is bypassed to both read ports.
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  generate
    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_size
      $error("reg_file_2r1w: NUM_REGS must equal 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_wr_ok;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_zero1;
  logic              w_zero2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wr_ok = wr_en && (wr_addr != '0);
  assign w_zero1 = (rd_addr1 == '0);
  assign w_zero2 = (rd_addr2 == '0);
  assign w_byp1  = wr_en && (wr_addr == rd_addr1);
  assign w_byp2  = wr_en && (wr_addr == rd_addr2);

  // Array update: reset clears everything and wins over a write; x0 never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Read port 1: forced zero in reset, x0 zero, then bypass, then array.
  always_comb begin
    w_rd1 = '0;
    if (!rst_n) begin
      w_rd1 = '0;
    end else if (w_zero1) begin
      w_rd1 = '0;
    end else if (w_byp1) begin
      w_rd1 = wr_data;
    end else begin
      w_rd1 = r_regs[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1 so equal indices give equal data.
  always_comb begin
    w_rd2 = '0;
    if (!rst_n) begin
      w_rd2 = '0;
    end else if (w_zero2) begin
      w_rd2 = '0;
    end else if (w_byp2) begin
      w_rd2 = wr_data;
    end else begin
      w_rd2 = r_regs[rd_addr2];
    end
  end

  assign rd_data1 = w_rd1;
  assign rd_data2 = w_rd2;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed vectors into a scoreboard queue,
// checked by an independent negedge monitor.
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  reg_file_2r1w #(
    .DATA_W(32),
    .ADDR_W(5),
    .NUM_REGS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so each queued entry is due
  // at the negedge following its stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (rd_data1 !== e.e1) begin
        bad++;
        $display("FAIL %s rd_data1: got %h want %h", e.nm, rd_data1, e.e1);
      end
      total++;
      if (rd_data2 !== e.e2) begin
        bad++;
        $display("FAIL %s rd_data2: got %h want %h", e.nm, rd_data2, e.e2);
      end
    end
  end

  task automatic step(
    input logic        rst,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [31:0] x1,
    input logic [31:0] x2,
    input string       nm
  );
    exp_t e;
    rst_n    = rst;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr1 = a1;
    rd_addr2 = a2;
    e.e1 = x1;
    e.e2 = x2;
    e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    @(posedge clk);
    #1;

    step(0, 1, 5'd7, 32'h1111_1111, 5'd7, 5'd0, 32'h0, 32'h0, "rst_hold");
    step(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6,
         32'hDEAD_BEEF, 32'h0, "preload5");
    step(0, 1, 5'd7, 32'h1111_1111, 5'd5, 5'd7, 32'h0, 32'h0, "rst_out");
    step(1, 0, 5'd0, 32'h0, 5'd5, 5'd7, 32'h0, 32'h0, "rst_clear");

    step(1, 1, 5'd3, 32'h1234_5678, 5'd3, 5'd5,
         32'h1234_5678, 32'h0, "wr_byp");
    step(1, 0, 5'd0, 32'h0, 5'd3, 5'd3,
         32'h1234_5678, 32'h1234_5678, "wr_lat");

    step(1, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd3,
         32'h0, 32'h1234_5678, "r0_same");
    step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, "r0_after");

    step(1, 1, 5'd9, 32'hAAAA_0000, 5'd9, 5'd0,
         32'hAAAA_0000, 32'h0, "pre9");
    step(1, 1, 5'd9, 32'h0000_BBBB, 5'd9, 5'd9,
         32'h0000_BBBB, 32'h0000_BBBB, "byp_both");
    step(1, 0, 5'd0, 32'h0, 5'd9, 5'd9,
         32'h0000_BBBB, 32'h0000_BBBB, "byp_after");

    step(1, 1, 5'd5, 32'h2, 5'd5, 5'd0, 32'h2, 32'h0, "pre5");
    step(1, 1, 5'd4, 32'h1, 5'd5, 5'd4, 32'h2, 32'h1, "byp_miss");

    for (int i = 1; i < 32; i++) begin
      step(1, 1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(i - 1),
           32'(i) * 32'h0101_0101,
           32'(i - 1) * 32'h0101_0101, "sweep_wr");
    end
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i),
           32'(i) * 32'h0101_0101,
           32'(31 - i) * 32'h0101_0101, "sweep_rd");
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(negedge clk);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Integer register file that consumes the 5-bit destination-register select produced by the destination-register 2:1 mux in the write-back path.
- Provides two combinational read ports for the decode stage and one clocked write port.
- Register 0 is hardwired to zero.
- A same-cycle write-to-read bypass lets decode see the value being written back without a stall.

Parameters:
- DATA_W, 32, width of each register and of all data ports
- ADDR_W, 5, register address width; fixed to match the 5-bit destination select
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- wr_en  input  1  write enable from write-back control
- wr_addr  input  ADDR_W  destination register index (output of the destination 2:1 mux)
- wr_data  input  DATA_W  write-back data
- rd_addr1  input  ADDR_W  read port 1 index (rs)
- rd_addr2  input  ADDR_W  read port 2 index (rt)
- rd_data1  output  DATA_W  read port 1 data
- rd_data2  output  DATA_W  read port 2 data

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low.
  - At a rising clk edge with rst_n=0, all NUM_REGS registers load 0.
  - Reset has priority over a simultaneous write; that write is dropped.
- Outputs while rst_n=0:
  - rd_data1 and rd_data2 are forced to 0 combinationally, regardless of array contents or bypass.
  - This covers the period before the first reset edge.
- Write:
  - At a rising clk edge with rst_n=1, wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Write latency is 1 cycle: a normal read returns the new value starting the cycle after the edge.
  - wr_en=0 leaves the array unchanged.
  - wr_en=1 with wr_addr=0 is silently ignored; reg[0] stays 0 permanently.
- Read (each port independent, combinational, zero latency, rst_n=1):
  - rd_addrN==0: rd_dataN = 0.
  - Else if wr_en=1 and wr_addr==rd_addrN: rd_dataN = wr_data (bypass).
  - Else: rd_dataN = reg[rd_addrN].
- Both ports addressing the same register return identical data, including under bypass.
- No X propagation:
  - With rst_n=1, any rd_addr value gives a defined output once reset has been applied.
  - Out-of-range indices cannot occur because NUM_REGS=2**ADDR_W; an elaboration check fails if this does not hold.
- No internal state besides the array; no handshake; no stall outputs.

Test Plan:
- Reset clear: preload reg5=0xDEADBEEF. Hold rst_n=0 for 1 edge with wr_en=1, wr_addr=7, wr_data=0x11111111. -> After release, rd_addr1=5 gives 0 and rd_addr2=7 gives 0. Both outputs read 0 while rst_n=0.
- Write/read latency: write wr_addr=3, wr_data=0x12345678, then deassert wr_en. -> Next cycle rd_addr1=3 gives 0x12345678. Before the edge, with wr_en still asserted, bypass gives 0x12345678.
- Register zero: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF. -> rd_addr1=0 gives 0 both in the same cycle (no bypass) and after the edge.
- Bypass both ports: reg9=0xAAAA0000. Drive wr_en=1, wr_addr=9, wr_data=0x0000BBBB, rd_addr1=rd_addr2=9. -> Both outputs read 0x0000BBBB that cycle, and reg9=0x0000BBBB afterward.
- Bypass miss: wr_en=1, wr_addr=4, wr_data=0x1; rd_addr1=5 with reg5=0x2. -> rd_data1=0x2.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31 on consecutive cycles, then read all 32 pairs. -> reg0=0 and every other register matches, with no aliasing.
